// File: rtl/glide_ctrl_pkg.sv
// Shared state encoding and default widths for the glide controller.
package glide_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } state_t;

   localparam int DEF_DSZ = 8;
   localparam int DEF_RSZ = 8;

endpackage

// File: rtl/glide_ctrl_rate_tick.sv
// Reloadable down-counter; emits a tick each time it reaches zero while running.
module glide_ctrl_rate_tick #(
   parameter int RSZ = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           run,
   input  logic           hold,
   input  logic [RSZ-1:0] rate,
   output logic           tick
);

   logic [RSZ-1:0] cnt;
   logic           adv;

   assign adv  = run && !hold;
   assign tick = adv && (cnt == '0);

   // Reload uses the live rate input, so rate changes land at the next reload.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= rate;
      end else if (adv) begin
         if (cnt == '0) cnt <= rate;
         else           cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/glide_ctrl.sv
// Slew controller: steps out toward an accepted target one LSB per rate tick.
module glide_ctrl
   import glide_ctrl_pkg::*;
#(
   parameter int DSZ = DEF_DSZ,
   parameter int RSZ = DEF_RSZ
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [DSZ-1:0] tgt,
   input  logic           tgt_valid,
   output logic           tgt_ready,
   input  logic [RSZ-1:0] rate,
   input  logic           hold,
   output logic [DSZ-1:0] out,
   output logic           busy,
   output logic           done
);

   state_t         state;
   state_t         state_nxt;
   logic [DSZ-1:0] target;
   logic [DSZ-1:0] out_nxt;
   logic           accept;
   logic           run;
   logic           dir;
   logic           tick;
   logic           step;
   logic           arrive;
   logic           same;

   glide_ctrl_rate_tick #(
      .RSZ (RSZ)
   ) u_rate_tick (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .run   (run),
      .hold  (hold),
      .rate  (rate),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               if (tgt > out)      state_nxt = ST_UP;
               else if (tgt < out) state_nxt = ST_DOWN;
               else                state_nxt = ST_IDLE;
            end
         end
         ST_UP, ST_DOWN: begin
            if (arrive) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != ST_IDLE);
      tgt_ready = (state == ST_IDLE) && !reset;
      accept    = tgt_valid && tgt_ready;
      run       = busy;
      dir       = (state == ST_UP);
   end

   assign step    = tick && !hold;
   assign out_nxt = dir ? out + 1'b1 : out - 1'b1;
   assign arrive  = step && (out_nxt == target);
   assign same    = accept && (tgt == out);

   always_ff @(posedge clk) begin
      if (reset) begin
         out    <= '0;
         target <= '0;
         done   <= 1'b0;
      end else begin
         done <= same || arrive;
         if (accept) target <= tgt;
         if (step)   out    <= out_nxt;
      end
   end

endmodule

// File: tb/tb_glide_ctrl.sv
// Directed bench for glide_ctrl with hand-computed step timing.
module tb_glide_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tgt;
   logic       tgt_valid;
   logic       tgt_ready;
   logic [7:0] rate;
   logic       hold;
   logic [7:0] out;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   glide_ctrl #(.DSZ(8), .RSZ(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .tgt       (tgt),
      .tgt_valid (tgt_valid),
      .tgt_ready (tgt_ready),
      .rate      (rate),
      .hold      (hold),
      .out       (out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic tk(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic st(input string tag, input int o, input int b,
                     input int d, input int r);
      chk({tag, ".out"}, int'(out), o);
      chk({tag, ".busy"}, int'(busy), b);
      chk({tag, ".done"}, int'(done), d);
      chk({tag, ".ready"}, int'(tgt_ready), r);
   endtask

   initial begin
      reset = 1'b1;
      tgt = 8'd0;
      tgt_valid = 1'b0;
      rate = 8'd0;
      hold = 1'b0;
      tk(2);
      chk("rst.ready_low", int'(tgt_ready), 0);
      reset = 1'b0;
      #1;
      st("rst", 0, 0, 0, 1);

      // 0 -> 13, rate 3: steps every 4 edges
      tgt = 8'd13; rate = 8'd3; tgt_valid = 1'b1;
      tk(1);
      tgt_valid = 1'b0;
      st("t1.acc", 0, 1, 0, 0);
      tk(3);
      chk("t1.e3", int'(out), 0);
      tk(1);
      chk("t1.e4", int'(out), 1);
      tk(47);
      st("t1.e51", 12, 1, 0, 0);
      tk(1);
      st("t1.e52", 13, 0, 1, 1);
      tk(1);
      st("t1.e53", 13, 0, 0, 1);

      // 13 -> 10, rate 0
      tgt = 8'd10; rate = 8'd0; tgt_valid = 1'b1;
      tk(1);
      tgt_valid = 1'b0;
      st("t2.acc", 13, 1, 0, 0);
      tk(1); st("t2.s1", 12, 1, 0, 0);
      tk(1); st("t2.s2", 11, 1, 0, 0);
      tk(1); st("t2.s3", 10, 0, 1, 1);
      tk(1); st("t2.post", 10, 0, 0, 1);

      // target equal to current value
      tgt = 8'd10; tgt_valid = 1'b1;
      tk(1);
      tgt_valid = 1'b0;
      st("t3.eq", 10, 0, 1, 1);
      tk(1);
      st("t3.post", 10, 0, 0, 1);

      // valid held during a glide: accepted only in the done cycle
      tgt = 8'd14; tgt_valid = 1'b1;
      tk(1);
      st("t6.acc", 10, 1, 0, 0);
      tgt = 8'd3;
      tk(1); st("t6.s1", 11, 1, 0, 0);
      tk(1); st("t6.s2", 12, 1, 0, 0);
      tk(1); st("t6.s3", 13, 1, 0, 0);
      tk(1); st("t6.s4", 14, 0, 1, 1);
      tk(1);
      tgt_valid = 1'b0;
      st("t6.acc2", 14, 1, 0, 0);
      tk(10);
      st("t6.e10", 4, 1, 0, 0);
      tk(1);
      st("t6.end", 3, 0, 1, 1);

      // reset mid-glide at out=100 heading to 200
      tgt = 8'd200; tgt_valid = 1'b1;
      tk(1);
      tgt_valid = 1'b0;
      tk(97);
      st("t5.pre", 100, 1, 0, 0);
      reset = 1'b1;
      tk(1);
      chk("t5.rst.out", int'(out), 0);
      chk("t5.rst.busy", int'(busy), 0);
      chk("t5.rst.done", int'(done), 0);
      reset = 1'b0;
      #1;
      chk("t5.ready", int'(tgt_ready), 1);
      tk(1);
      st("t5.post", 0, 0, 0, 1);

      // 0 -> 255 at rate 1 with 7 hold cycles
      tgt = 8'd255; rate = 8'd1; tgt_valid = 1'b1;
      tk(1);
      tgt_valid = 1'b0;
      tk(101);
      st("t4.e101", 50, 1, 0, 0);
      hold = 1'b1;
      tk(3);
      st("t4.h3", 50, 1, 0, 0);
      tk(4);
      st("t4.h7", 50, 1, 0, 0);
      hold = 1'b0;
      tk(1);
      st("t4.phase", 51, 1, 0, 0);
      tk(1);
      chk("t4.phase2", int'(out), 51);
      tk(406);
      st("t4.e516", 254, 1, 0, 0);
      tk(1);
      st("t4.e517", 255, 0, 1, 1);
      tk(1);
      st("t4.nowrap", 255, 0, 0, 1);

      // hold in IDLE still accepts; stepping waits for release
      hold = 1'b1; rate = 8'd0; tgt = 8'd250; tgt_valid = 1'b1;
      tk(1);
      tgt_valid = 1'b0;
      st("th.acc", 255, 1, 0, 0);
      tk(1);
      st("th.frz", 255, 1, 0, 0);
      hold = 1'b0;
      tk(1);
      st("th.s1", 254, 1, 0, 0);
      tk(4);
      st("th.end", 250, 0, 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
